// File: rtl/rpe_weight_loader.sv
// Weight-side transmitter for the RPE systolic array: encodes rows of signed 8-bit weights into
// 5-bit RPE codes, buffers a SIZE x SIZE tile and shifts it into the top row, last row first.

module rpe_weight_enc (
    input  logic [7:0] w,
    output logic [4:0] code,
    output logic       lossy
);
    logic       neg;
    logic       big;
    logic [7:0] mag;
    logic [2:0] m;
    logic [2:0] x;

    always_comb begin
        neg = w[7];
        mag = neg ? (~w + 8'd1) : w;
        // Zero shares the 16*m form; everything above 15 rounds to a multiple of 16.
        big = (mag > 8'd15) || (mag == 8'd0);
        m   = (mag[3:0] > 4'd8) ? mag[6:4] + 3'd1 : mag[6:4];
        if (mag > 8'd112)
            x = 3'd7;
        else if (big)
            x = m;
        else
            x = mag[0] ? mag[3:1] : mag[3:1] - 3'd1;
        // Negative codes are the bitwise complement of the positive magnitude index.
        code  = {big, neg ? ~{1'b0, x} : {1'b0, x}};
        lossy = big ? ((mag > 8'd112) || (mag[3:0] != 4'd0)) : !mag[0];
    end
endmodule

module rpe_weight_loader #(
    parameter int SIZE = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             w_in_valid,
    output logic                             w_in_ready,
    input  logic [8*SIZE-1:0]                w_in_data,
    input  logic                             shift_en,
    output logic                             w_out_valid,
    output logic [5*SIZE-1:0]                w_out_data,
    output logic                             busy,
    output logic                             load_done,
    output logic                             lossy,
    output logic [$clog2(SIZE*SIZE+1)-1:0]   lossy_cnt
);
    localparam int RW   = $clog2(SIZE);
    localparam int CW   = $clog2(SIZE*SIZE+1);
    localparam int MAXC = SIZE*SIZE;

    typedef enum logic [1:0] {FILL, SHIFT, DONE} state_t;

    state_t                     state, state_nxt;
    logic [RW-1:0]              row_cnt, idx;
    logic [SIZE-1:0][4:0]       enc_code;
    logic [SIZE-1:0]            enc_lossy;
    logic [SIZE-1:0][5*SIZE-1:0] tile_buf;
    logic [CW-1:0]              row_lossy;
    logic [CW:0]                cnt_sum;
    logic                       accept, last_row;

    for (genvar c = 0; c < SIZE; c++) begin : g_lane
        rpe_weight_enc u_enc (
            .w     (w_in_data[8*c +: 8]),
            .code  (enc_code[c]),
            .lossy (enc_lossy[c])
        );
    end

    always_comb begin
        row_lossy = '0;
        for (int c = 0; c < SIZE; c++)
            row_lossy = row_lossy + CW'(enc_lossy[c]);
    end

    assign accept   = w_in_valid && w_in_ready;
    assign last_row = (row_cnt == RW'(SIZE-1));
    // Row 0 of a tile restarts the count rather than accumulating onto the previous tile.
    assign cnt_sum  = (row_cnt == '0) ? {1'b0, row_lossy}
                                      : {1'b0, lossy_cnt} + {1'b0, row_lossy};

    always_comb begin
        state_nxt  = state;
        w_in_ready = 1'b0;
        busy       = 1'b1;
        case (state)
            FILL: begin
                w_in_ready = 1'b1;
                busy       = 1'b0;
                if (w_in_valid && last_row)
                    state_nxt = SHIFT;
            end
            SHIFT: if (shift_en && idx == '0) state_nxt = DONE;
            DONE:  state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= FILL;
            row_cnt     <= '0;
            idx         <= '0;
            w_out_valid <= 1'b0;
            w_out_data  <= '0;
            load_done   <= 1'b0;
            lossy       <= 1'b0;
            lossy_cnt   <= '0;
        end else begin
            state       <= state_nxt;
            load_done   <= (state == DONE);
            w_out_valid <= (state == SHIFT) && shift_en;
            if (state == SHIFT && shift_en) begin
                w_out_data <= tile_buf[idx];
                if (idx != '0)
                    idx <= idx - RW'(1);
            end
            if (accept) begin
                row_cnt   <= last_row ? '0 : row_cnt + RW'(1);
                lossy_cnt <= (cnt_sum > (CW+1)'(MAXC)) ? CW'(MAXC) : cnt_sum[CW-1:0];
                lossy     <= ((row_cnt != '0) && lossy) || (row_lossy != '0);
                if (last_row)
                    idx <= RW'(SIZE-1);
            end
        end
    end

    // Buffer contents are don't-care after reset, so no reset branch here.
    always_ff @(posedge clk) begin
        if (accept)
            tile_buf[row_cnt] <= enc_code;
    end
endmodule
